// File: rtl/fb_sched_pkg.sv
// Shared types and defaults for the SDRAM framebuffer scheduler.
// Command codes match the SDRAM controller command port.
package fb_sched_pkg;

    localparam int ADDR_W         = 22;
    localparam int FRAME_WORDS_DEF = 153600;
    localparam int BURST_DEF      = 8;
    localparam int RD_DEPTH_DEF   = 32;
    localparam int RD_URGENT_DEF  = 8;
    localparam int MAX_CONSEC_DEF = 4;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2
    } sdram_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ
    } sched_state_e;

endpackage

// File: rtl/framebuffer_scheduler_if.sv
// Bundle between scheduler, write/read FIFOs and the SDRAM controller.
// master = scheduler side, slave = FIFO/controller side.
interface framebuffer_scheduler_if;
    import fb_sched_pkg::*;

    logic [4:0]        wr_used;
    logic              wr_pop;
    logic              wr_frame_start;
    logic [5:0]        rd_used;
    logic              rd_push;
    logic [1:0]        command;
    logic [ADDR_W-1:0] data_address;
    logic              data_read_valid;
    logic              data_write_done;
    logic              busy;

    modport master (
        input  wr_used, wr_frame_start, rd_used,
        input  data_read_valid, data_write_done,
        output wr_pop, rd_push, command, data_address, busy
    );

    modport slave (
        output wr_used, wr_frame_start, rd_used,
        output data_read_valid, data_write_done,
        input  wr_pop, rd_push, command, data_address, busy
    );

endinterface

// File: rtl/burst_addr_gen.sv
// Frame offset and buffer-select tracker for one stream.
// Steps one burst at a time; on frame wrap loads the next buffer bit.
module burst_addr_gen
    import fb_sched_pkg::*;
#(
    parameter int   FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int   BURST       = BURST_DEF,
    parameter logic BUF_RST     = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_step,
    input  logic              i_clear,
    input  logic              i_wrap_buf,
    output logic [ADDR_W-1:0] o_off,
    output logic              o_buf,
    output logic              o_wrap
);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(BURST);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(FRAME_WORDS);

    logic [ADDR_W-1:0] r_off;
    logic              r_buf;
    logic [ADDR_W-1:0] w_next;

    assign w_next = r_off + STEP;
    assign o_wrap = i_step && (w_next == LIMIT);
    assign o_off  = r_off;
    assign o_buf  = r_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_off <= '0;
            r_buf <= BUF_RST;
        end else if (i_clear) begin
            r_off <= '0;
        end else if (i_step) begin
            if (o_wrap) begin
                r_off <= '0;
                r_buf <= i_wrap_buf;
            end else begin
                r_off <= w_next;
            end
        end
    end

endmodule

// File: rtl/framebuffer_scheduler.sv
// Arbitrates SDRAM bursts between camera writes and display reads,
// double-buffering frames so display only reads completed frames.
module framebuffer_scheduler
    import fb_sched_pkg::*;
#(
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int BURST       = BURST_DEF,
    parameter int RD_DEPTH    = RD_DEPTH_DEF,
    parameter int RD_URGENT   = RD_URGENT_DEF,
    parameter int MAX_CONSEC  = MAX_CONSEC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    framebuffer_scheduler_if.master bus
);
    localparam int BEAT_W = $clog2(BURST) + 1;
    localparam int CONS_W = $clog2(MAX_CONSEC + 1);

    localparam logic [5:0]        RD_LIM     = 6'(RD_DEPTH - BURST);
    localparam logic [5:0]        RD_URG     = 6'(RD_URGENT);
    localparam logic [4:0]        WR_MIN     = 5'(BURST);
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST - 1);
    localparam logic [CONS_W-1:0] CONS_MAX   = CONS_W'(MAX_CONSEC);
    localparam logic [ADDR_W-1:0] FRAME_BASE = ADDR_W'(FRAME_WORDS);

    sched_state_e      r_state;
    sched_state_e      w_next;
    sdram_cmd_e        r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [BEAT_W-1:0] r_beat;
    logic [CONS_W-1:0] r_consec;
    logic              r_last_wr;
    logic              r_done_buf;
    logic              r_pend;

    logic              w_idle, w_rd_ok, w_rd_urg, w_wr_ok;
    logic              w_gnt_wr, w_gnt_rd;
    logic              w_wr_beat, w_rd_beat, w_last;
    logic              w_wr_step, w_rd_step, w_wr_clr;
    logic [ADDR_W-1:0] w_wr_off, w_rd_off, w_wr_addr, w_rd_addr;
    logic              w_wr_buf, w_rd_buf, w_wr_wrap, w_rd_wrap_unused;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_rd_ok   = bus.rd_used <= RD_LIM;
    assign w_rd_urg  = bus.rd_used < RD_URG;
    assign w_wr_ok   = bus.wr_used >= WR_MIN;
    assign w_wr_beat = (r_state == ST_WRITE) && bus.data_write_done;
    assign w_rd_beat = (r_state == ST_READ) && bus.data_read_valid;
    assign w_last    = (w_wr_beat || w_rd_beat) && (r_beat == BEAT_LAST);
    assign w_wr_step = w_wr_beat && w_last;
    assign w_rd_step = w_rd_beat && w_last;
    assign w_wr_clr  = w_idle && r_pend;

    // A pending frame restart must already affect this cycle's grant address
    assign w_wr_addr = (w_wr_buf ? FRAME_BASE : '0)
                     + (w_wr_clr ? '0 : w_wr_off);
    assign w_rd_addr = (w_rd_buf ? FRAME_BASE : '0) + w_rd_off;

    assign bus.wr_pop       = w_wr_beat;
    assign bus.rd_push      = w_rd_beat;
    assign bus.command      = r_cmd;
    assign bus.data_address = r_addr;
    assign bus.busy         = !w_idle;

    burst_addr_gen #(
        .FRAME_WORDS(FRAME_WORDS),
        .BURST      (BURST),
        .BUF_RST    (1'b0)
    ) u_wr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_step    (w_wr_step),
        .i_clear   (w_wr_clr),
        .i_wrap_buf(~w_wr_buf),
        .o_off     (w_wr_off),
        .o_buf     (w_wr_buf),
        .o_wrap    (w_wr_wrap)
    );

    burst_addr_gen #(
        .FRAME_WORDS(FRAME_WORDS),
        .BURST      (BURST),
        .BUF_RST    (1'b1)
    ) u_rd_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_step    (w_rd_step),
        .i_clear   (1'b0),
        .i_wrap_buf(r_done_buf),
        .o_off     (w_rd_off),
        .o_buf     (w_rd_buf),
        .o_wrap    (w_rd_wrap_unused)
    );

    always_comb begin
        w_gnt_wr = 1'b0;
        w_gnt_rd = 1'b0;
        w_next   = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_rd_ok && w_rd_urg)
                    w_gnt_rd = 1'b1;
                else if (r_consec == CONS_MAX && r_last_wr && w_rd_ok)
                    w_gnt_rd = 1'b1;
                else if (r_consec == CONS_MAX && !r_last_wr && w_wr_ok)
                    w_gnt_wr = 1'b1;
                else if (w_wr_ok)
                    w_gnt_wr = 1'b1;
                else if (w_rd_ok)
                    w_gnt_rd = 1'b1;
                if (w_gnt_wr)
                    w_next = ST_WRITE;
                else if (w_gnt_rd)
                    w_next = ST_READ;
            end
            ST_WRITE, ST_READ: begin
                if (w_last)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cmd      <= CMD_IDLE;
            r_addr     <= '0;
            r_beat     <= '0;
            r_consec   <= '0;
            r_last_wr  <= 1'b0;
            r_done_buf <= 1'b1;
            r_pend     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_gnt_wr) begin
                r_cmd  <= CMD_WRITE;
                r_addr <= w_wr_addr;
                r_beat <= '0;
            end else if (w_gnt_rd) begin
                r_cmd  <= CMD_READ;
                r_addr <= w_rd_addr;
                r_beat <= '0;
            end else begin
                if (w_last)
                    r_cmd <= CMD_IDLE;
                if (w_wr_beat || w_rd_beat)
                    r_beat <= r_beat + BEAT_W'(1);
            end
            // Saturate so a long single-type run still yields at the limit
            if (w_gnt_wr || w_gnt_rd) begin
                r_last_wr <= w_gnt_wr;
                if (w_gnt_wr != r_last_wr)
                    r_consec <= CONS_W'(1);
                else if (r_consec != CONS_MAX)
                    r_consec <= r_consec + CONS_W'(1);
            end
            if (w_wr_wrap)
                r_done_buf <= w_wr_buf;
            r_pend <= ((r_pend && !w_idle) || bus.wr_frame_start)
                   && !w_wr_wrap;
        end
    end

endmodule

// File: tb/tb_framebuffer_scheduler.sv
// Directed bench for framebuffer_scheduler: grant table, starvation,
// mid-burst reset, frame restart and buffer swap on wrap.
module tb_framebuffer_scheduler;
    import fb_sched_pkg::*;

    // Reduced frame keeps full-frame wrap sequences short
    localparam int FW = 1600;
    localparam int B  = 8;

    typedef struct {
        logic [4:0]  wr;
        logic [5:0]  rd;
        logic [1:0]  cmd;
        logic [21:0] addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    framebuffer_scheduler_if bus();

    framebuffer_scheduler #(
        .FRAME_WORDS(FW),
        .BURST      (B),
        .RD_DEPTH   (32),
        .RD_URGENT  (8),
        .MAX_CONSEC (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_burst(input logic [1:0] cmd,
                            output logic [21:0] addr, output bit ok);
        int n;
        int pops;
        ok   = 1'b0;
        addr = '0;
        n    = 0;
        while (bus.command == 2'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.command != cmd || !bus.busy) return;
        addr = bus.data_address;
        pops = 0;
        for (int i = 0; i < B; i++) begin
            if (cmd == 2'd1) bus.data_write_done = 1'b1;
            else bus.data_read_valid = 1'b1;
            #1;
            if ((cmd == 2'd1) ? bus.wr_pop : bus.rd_push) pops++;
            @(negedge clk);
        end
        bus.data_write_done = 1'b0;
        bus.data_read_valid = 1'b0;
        ok = (pops == B) && (bus.command == 2'd0) && !bus.busy;
    endtask

    task automatic run_n(input logic [1:0] cmd, input int n,
                         input int base, input string nm);
        logic [21:0] a;
        bit ok;
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            do_burst(cmd, a, ok);
            if (!ok || a != 22'(base + B * i)) bad++;
            if (!ok) break;
        end
        check(nm, bad, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.wr_used = 5'd0;
        bus.rd_used = 6'd32;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[8];
        logic [1:0]  sc[6];
        logic [21:0] sa[6];
        logic [21:0] a;
        bit          ok;
        bit          seen;
        int          n;

        vt[0] = '{5'd8,  6'd32, 2'd1, 22'd0};
        vt[1] = '{5'd7,  6'd25, 2'd0, 22'd0};
        vt[2] = '{5'd16, 6'd24, 2'd1, 22'd8};
        vt[3] = '{5'd0,  6'd24, 2'd2, 22'(FW)};
        vt[4] = '{5'd16, 6'd7,  2'd2, 22'(FW + 8)};
        vt[5] = '{5'd16, 6'd8,  2'd1, 22'd16};
        vt[6] = '{5'd31, 6'd0,  2'd2, 22'(FW + 16)};
        vt[7] = '{5'd8,  6'd31, 2'd1, 22'd24};

        sc = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
        sa = '{22'd0, 22'd8, 22'd16, 22'd24, 22'(FW), 22'd32};

        bus.wr_used         = 5'd0;
        bus.rd_used         = 6'd32;
        bus.wr_frame_start  = 1'b0;
        bus.data_read_valid = 1'b0;
        bus.data_write_done = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_command", bus.command, 0);
        check("rst_address", bus.data_address, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_wr_pop", bus.wr_pop, 0);
        check("rst_rd_push", bus.rd_push, 0);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        bus.data_write_done = 1'b1;
        bus.data_read_valid = 1'b1;
        #1;
        check("stray_wr_pop", bus.wr_pop, 0);
        check("stray_rd_push", bus.rd_push, 0);
        @(negedge clk);
        bus.data_write_done = 1'b0;
        bus.data_read_valid = 1'b0;
        check("stray_no_cmd", bus.command, 0);

        for (int i = 0; i < 8; i++) begin
            bus.wr_used = vt[i].wr;
            bus.rd_used = vt[i].rd;
            if (vt[i].cmd == 2'd0) begin
                seen = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (bus.command != 2'd0 || bus.busy) seen = 1'b1;
                end
                check($sformatf("vec%0d_idle", i), 32'(seen), 0);
            end else begin
                do_burst(vt[i].cmd, a, ok);
                check($sformatf("vec%0d_ok", i), 32'(ok), 1);
                check($sformatf("vec%0d_addr", i), a, vt[i].addr);
            end
        end

        do_reset();
        bus.wr_used = 5'd16;
        bus.rd_used = 6'd20;
        for (int i = 0; i < 6; i++) begin
            do_burst(sc[i], a, ok);
            check($sformatf("starve%0d_ok", i), 32'(ok), 1);
            check($sformatf("starve%0d_addr", i), a, sa[i]);
        end

        bus.wr_used = 5'd8;
        bus.rd_used = 6'd32;
        n = 0;
        while (bus.command == 2'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midrst_cmd_before", bus.command, 1);
        check("midrst_addr_before", bus.data_address, 40);
        repeat (3) begin
            bus.data_write_done = 1'b1;
            @(negedge clk);
        end
        bus.data_write_done = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_cmd", bus.command, 0);
        check("midrst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_burst(2'd1, a, ok);
        check("midrst_after_ok", 32'(ok), 1);
        check("midrst_after_addr", a, 0);

        run_n(2'd1, 99, 8, "fill_to_800");
        bus.wr_used = 5'd0;
        bus.wr_frame_start = 1'b1;
        @(negedge clk);
        bus.wr_frame_start = 1'b0;
        bus.wr_used = 5'd8;
        do_burst(2'd1, a, ok);
        check("fstart_ok", 32'(ok), 1);
        check("fstart_addr", a, 0);

        run_n(2'd1, FW / B - 1, 8, "wr_frame_rest");
        do_burst(2'd1, a, ok);
        check("wr_swap_ok", 32'(ok), 1);
        check("wr_swap_addr", a, FW);

        bus.wr_used = 5'd0;
        bus.rd_used = 6'd16;
        run_n(2'd2, FW / B, FW, "rd_frame_buf1");
        do_burst(2'd2, a, ok);
        check("rd_wrap_ok", 32'(ok), 1);
        check("rd_wrap_addr", a, 0);
        bus.rd_used = 6'd32;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
